// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD driver: FSM state codes,
// panel command bytes, default timing at 27 MHz and small decode helpers.
// The WRAP state exists only when LCD_DRIVER_AUTOWRAP_EN is defined.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP   = 3'd0,
        ST_INIT      = 3'd1,
        ST_IDLE      = 3'd2,
        ST_SETUP     = 3'd3,
        ST_EN_HIGH   = 3'd4,
        ST_EN_HOLD   = 3'd5,
        ST_EXEC_WAIT = 3'd6
`ifdef LCD_DRIVER_AUTOWRAP_EN
        ,
        ST_WRAP      = 3'd7
`endif
    } lcd_state_t;

    localparam logic [7:0] CMD_FUNCSET = 8'h38;
    localparam logic [7:0] CMD_DISPON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_LINE0   = 8'h80;
    localparam logic [7:0] CMD_LINE1   = 8'hC0;

    localparam int DEF_POWERUP_CYC = 405000;  // 15 ms
    localparam int DEF_EN_CYC      = 16;      // ~600 ns
    localparam int DEF_EXEC_CYC    = 1080;    // 40 us
    localparam int DEF_CLR_CYC     = 44280;   // 1.64 ms

    // Power-on command sequence, indexed by position
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNCSET;
            2'd1:    return CMD_DISPON;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

    // Clear and home need the long execute time; characters never do
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by every timed state of the LCD driver.
// done is high in the last cycle of a load_val-long wait; idle flags an
// empty counter so the power-up wait can arm itself after reset.
module lcd_delay_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done,
    output logic         idle
);

    logic [W-1:0] count;

    // Count down to zero; a load always takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == W'(1));
    assign idle = (count == '0);

endmodule

// File: rtl/lcd_hd44780_driver.sv
// HD44780 8-bit write-only driver: power-on wait, fixed init sequence, then
// one byte transaction at a time (SETUP, EN pulse, EN hold, execute wait).
// Tracks the cursor (col/line). Define LCD_DRIVER_AUTOWRAP_EN to have the
// driver re-address the next line itself after column 15 is written.
module lcd_hd44780_driver
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC = DEF_POWERUP_CYC,
    parameter int EN_CYC      = DEF_EN_CYC,
    parameter int EXEC_CYC    = DEF_EXEC_CYC,
    parameter int CLR_CYC     = DEF_CLR_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_ON,
    output logic       LCD_BLON,
    output logic       busy,
    output logic [2:0] fsm_state
);

    localparam int MAX_A   = (POWERUP_CYC > CLR_CYC) ? POWERUP_CYC : CLR_CYC;
    localparam int MAX_B   = (EXEC_CYC > EN_CYC) ? EXEC_CYC : EN_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam logic [2:0] INIT_LEN = 3'd4;

    lcd_state_t       state, next_state;
    logic             cur_rs;
    logic [7:0]       cur_data;
    logic [3:0]       col;
    logic             line;
    logic [2:0]       init_idx;
`ifdef LCD_DRIVER_AUTOWRAP_EN
    logic             wrap_pend;
`endif
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;
    logic             tmr_idle;

    lcd_delay_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done),
        .idle     (tmr_idle)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_POWERUP;
        end else begin
            state <= next_state;
        end
    end

    // Next state and timer loads; each wait is armed on the edge that enters it
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        unique case (state)
            ST_POWERUP: begin
                // Counter is empty only in the first cycle after reset; the
                // arming cycle is part of the wait, hence the minus one.
                if (tmr_idle) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(POWERUP_CYC - 1);
                end else if (tmr_done) begin
                    next_state = ST_INIT;
                end
            end
            ST_INIT: next_state = ST_SETUP;
            ST_IDLE: begin
                if (req_valid) next_state = ST_SETUP;
            end
            ST_SETUP: begin
                next_state = ST_EN_HIGH;
                tmr_load   = 1'b1;
                tmr_val    = TMR_W'(EN_CYC);
            end
            ST_EN_HIGH: begin
                if (tmr_done) begin
                    next_state = ST_EN_HOLD;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(EN_CYC);
                end
            end
            ST_EN_HOLD: begin
                if (tmr_done) begin
                    next_state = ST_EXEC_WAIT;
                    tmr_load   = 1'b1;
                    tmr_val    = is_long_cmd(cur_rs, cur_data) ? TMR_W'(CLR_CYC)
                                                               : TMR_W'(EXEC_CYC);
                end
            end
            ST_EXEC_WAIT: begin
                if (tmr_done) begin
                    if (init_idx != INIT_LEN) begin
                        next_state = ST_INIT;
`ifdef LCD_DRIVER_AUTOWRAP_EN
                    end else if (wrap_pend) begin
                        next_state = ST_WRAP;
`endif
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
`ifdef LCD_DRIVER_AUTOWRAP_EN
            ST_WRAP: next_state = ST_SETUP;
`endif
            default: next_state = ST_POWERUP;
        endcase
    end

    // Byte capture, init sequencing and cursor tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_rs    <= 1'b0;
            cur_data  <= 8'h00;
            col       <= 4'd0;
            line      <= 1'b0;
            init_idx  <= 3'd0;
`ifdef LCD_DRIVER_AUTOWRAP_EN
            wrap_pend <= 1'b0;
`endif
        end else begin
            case (state)
                ST_INIT: begin
                    cur_rs   <= 1'b0;
                    cur_data <= init_cmd(init_idx[1:0]);
                    init_idx <= init_idx + 3'd1;
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        cur_rs   <= req_rs;
                        cur_data <= req_data;
                    end
                end
                ST_SETUP: begin
                    if (cur_rs) begin
                        // 4-bit col rolls 15 -> 0 on its own
                        col <= col + 4'd1;
                        if (col == 4'hF) begin
                            line <= ~line;
`ifdef LCD_DRIVER_AUTOWRAP_EN
                            wrap_pend <= 1'b1;
`endif
                        end
                    end else if (is_long_cmd(1'b0, cur_data)) begin
                        col  <= 4'd0;
                        line <= 1'b0;
                    end else if (cur_data[7]) begin
                        col  <= cur_data[3:0];
                        line <= cur_data[6];
                    end
                end
`ifdef LCD_DRIVER_AUTOWRAP_EN
                ST_WRAP: begin
                    // line already holds the new line from the wrapping write
                    cur_rs    <= 1'b0;
                    cur_data  <= line ? CMD_LINE1 : CMD_LINE0;
                    wrap_pend <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    assign LCD_EN    = (state == ST_EN_HIGH);
    assign LCD_RS    = cur_rs;
    assign LCD_DATA  = cur_data;
    assign LCD_RW    = 1'b0;
    assign LCD_ON    = 1'b1;
    assign LCD_BLON  = 1'b1;
    assign req_ready = (state == ST_IDLE);
    assign busy      = ~req_ready;
    assign fsm_state = state;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Randomized bench for lcd_hd44780_driver with a transaction-level model:
// expected panel byte stream, cursor and latency derived from the rules.
`timescale 1ns/1ps
module tb_lcd_hd44780_driver;

    localparam int P_PWR  = 20;
    localparam int P_EN   = 2;
    localparam int P_EXEC = 5;
    localparam int P_CLR  = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready;
    logic [7:0] LCD_DATA;
    logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;
    logic       busy;
    logic [2:0] fsm_state;

    int checks = 0;
    int failures = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int m_col = 0;
    int m_line = 0;

    always #5 clk = ~clk;

    lcd_hd44780_driver #(
        .POWERUP_CYC (P_PWR),
        .EN_CYC      (P_EN),
        .EXEC_CYC    (P_EXEC),
        .CLR_CYC     (P_CLR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .LCD_DATA  (LCD_DATA),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_EN    (LCD_EN),
        .LCD_ON    (LCD_ON),
        .LCD_BLON  (LCD_BLON),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Panel-side monitor: record every EN pulse, check width and bus stability
    logic       prev_en = 1'b0;
    int         en_w = 0;
    int         hold_left = 0;
    logic [8:0] pulse_v = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en   <= 1'b0;
            en_w      <= 0;
            hold_left <= 0;
        end else begin
            prev_en <= LCD_EN;
            if (LCD_EN) begin
                if (!prev_en) begin
                    got_q.push_back({LCD_RS, LCD_DATA});
                    pulse_v <= {LCD_RS, LCD_DATA};
                    en_w    <= 1;
                end else begin
                    en_w <= en_w + 1;
                    chk("en_bus_stable", 32'({LCD_RS, LCD_DATA}), 32'(pulse_v));
                end
            end else if (prev_en) begin
                chk("en_width", 32'(en_w), 32'(P_EN));
                chk("hold_bus_stable", 32'({LCD_RS, LCD_DATA}), 32'(pulse_v));
                hold_left <= P_EN - 1;
            end else if (hold_left > 0) begin
                chk("hold_bus_stable", 32'({LCD_RS, LCD_DATA}), 32'(pulse_v));
                hold_left <= hold_left - 1;
            end
        end
    end

    // Model: expected panel bytes and cursor; returns 1 when a line wrap happens
    function automatic bit model_xfer(input logic rs, input logic [7:0] d);
        bit wrapped = 1'b0;
        exp_q.push_back({rs, d});
        if (rs) begin
            if (m_col == 15) begin
                m_col   = 0;
                m_line ^= 1;
                wrapped = 1'b1;
            end else begin
                m_col++;
            end
        end else if (d == 8'h01 || d == 8'h02) begin
            m_col  = 0;
            m_line = 0;
        end else if (d[7]) begin
            m_col  = int'(d[3:0]);
            m_line = int'(d[6]);
        end
`ifdef LCD_DRIVER_AUTOWRAP_EN
        if (wrapped) exp_q.push_back({1'b0, (m_line != 0) ? 8'hC0 : 8'h80});
`endif
        return wrapped;
    endfunction

    function automatic int wait_of(input logic rs, input logic [7:0] d);
        return (!rs && (d == 8'h01 || d == 8'h02)) ? P_CLR : P_EXEC;
    endfunction

    task automatic compare_bus(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_col"}, 32'(dut.col), 32'(m_col));
        chk({tag, "_line"}, 32'(dut.line), 32'(m_line));
    endtask

    // One request from IDLE; measures accept-to-ready latency and execute time
    task automatic send(input logic rs, input logic [7:0] d);
        int n = 0;
        int ex = 0;
        int lat_exp;
        int ex_exp;
        bit wrapped;
        req_rs    = rs;
        req_data  = d;
        req_valid = 1'b1;
        while (!req_ready && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        wrapped = model_xfer(rs, d);
        lat_exp = 2 + 2 * P_EN + wait_of(rs, d);
        ex_exp  = wait_of(rs, d);
`ifdef LCD_DRIVER_AUTOWRAP_EN
        if (wrapped) begin
            lat_exp += 2 + 2 * P_EN + P_EXEC;
            ex_exp  += P_EXEC;
        end
`else
        if (wrapped) ex_exp += 0;
`endif
        @(posedge clk);
        n = 1;
        @(negedge clk); #1;
        req_valid = 1'b0;
        chk("busy_after_accept", 32'({busy, req_ready}), 32'd2);
        while (!req_ready && n < 3000) begin
            if (fsm_state == 3'd6) ex++;
            @(negedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(lat_exp));
        chk("exec_cycles", 32'(ex), 32'(ex_exp));
        chk_cursor("cursor");
    endtask

    // Release reset and expect the full init sequence
    task automatic init_run();
        int n = 0;
        m_col  = 0;
        m_line = 0;
        void'(model_xfer(1'b0, 8'h38));
        void'(model_xfer(1'b0, 8'h0C));
        void'(model_xfer(1'b0, 8'h01));
        void'(model_xfer(1'b0, 8'h06));
        rst_n = 1'b1;
        while (!req_ready && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("init_latency", 32'(n),
            32'(P_PWR + 3 * (2 + 2 * P_EN + P_EXEC) + (2 + 2 * P_EN + P_CLR)));
        compare_bus("init_bus");
        chk_cursor("init_cursor");
    endtask

    // Request held valid across busy periods; data changes every cycle
    task automatic stream(input int cnt);
        int acc = 0;
        int guard = 0;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'($urandom_range(32, 126));
        while (acc < cnt && guard < 5000) begin
            if (req_ready) begin
                void'(model_xfer(1'b1, req_data));
                acc++;
            end
            @(negedge clk); #1;
            req_data = 8'($urandom_range(32, 126));
            guard++;
        end
        req_valid = 1'b0;
        chk("stream_accepts", 32'(acc), 32'(cnt));
        guard = 0;
        while (!req_ready && guard < 3000) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("stream_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int n;
        logic [7:0] cmds [5];
        cmds[0] = 8'h0C; cmds[1] = 8'h06; cmds[2] = 8'h10; cmds[3] = 8'h14; cmds[4] = 8'h38;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_en", 32'(LCD_EN), 32'd0);
        chk("rst_rs", 32'(LCD_RS), 32'd0);
        chk("rst_data", 32'(LCD_DATA), 32'h00);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_state", 32'(fsm_state), 32'd0);
        chk("const_pins", 32'({LCD_RW, LCD_ON, LCD_BLON}), 32'b011);

        init_run();

        send(1'b1, 8'h48);
        compare_bus("char_h");

        // 16 characters from column 0 must cross to line 1
        send(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) send(1'b1, 8'($urandom_range(32, 126)));
        compare_bus("wrap16");
        chk("wrap_line", 32'(dut.line), 32'd1);
        chk("wrap_col", 32'(dut.col), 32'd0);

        // Random mix of characters, clear/home, address and plain commands
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 6)       send(1'b1, 8'($urandom_range(32, 126)));
            else if (kind == 6) send(1'b0, ($urandom_range(0, 1) != 0) ? 8'h01 : 8'h02);
            else if (kind == 7) send(1'b0, 8'($urandom_range(128, 255)));
            else                send(1'b0, cmds[$urandom_range(0, 4)]);
        end
        compare_bus("random");

        stream(6);
        compare_bus("stream");
        chk_cursor("stream_cursor");

        for (int i = 0; i < 5; i++) send(1'b1, 8'($urandom_range(32, 126)));
        send(1'b0, 8'h01);
        chk("clear_col", 32'(dut.col), 32'd0);
        chk("clear_line", 32'(dut.line), 32'd0);
        compare_bus("clear");

        // Reset in the middle of an EN pulse
        req_rs = 1'b1; req_data = 8'h5A; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!LCD_EN && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("en_seen", 32'(LCD_EN), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_en", 32'(LCD_EN), 32'd0);
        chk("midrst_state", 32'(fsm_state), 32'd0);
        chk("midrst_ready_busy", 32'({busy, req_ready}), 32'd2);
        chk("midrst_data", 32'({LCD_RS, LCD_DATA}), 32'd0);
        chk("midrst_col", 32'(dut.col), 32'd0);
        got_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        init_run();
        send(1'b1, 8'h41);
        compare_bus("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
